// File: rtl/inst_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction ROM
// between the CPU fetch port and the debug/display port.
module inst_rom_arbiter #(
  parameter int ROM_AW = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic [31:0]       addr0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rerr0,
  input  logic              req1,
  input  logic [31:0]       addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rerr1,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [15:0]       busy_cnt
);

  logic              last_grant;
  logic              p_valid;
  logic              p_port;
  logic              p_err;
  logic [ROM_AW-1:0] addr_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] resp_data;
  logic              oor0;
  logic              oor1;
  logic [ROM_AW-1:0] wa0;
  logic [ROM_AW-1:0] wa1;
  logic              unused_bits;

  assign unused_bits = ^{addr0[1:0], addr1[1:0]};

  assign wa0  = addr0[ROM_AW+1:2];
  assign wa1  = addr1[ROM_AW+1:2];
  assign oor0 = |addr0[31:ROM_AW+2];
  assign oor1 = |addr1[31:ROM_AW+2];

  // Grants are masked in reset so outputs drop immediately.
  assign gnt0 = resetn & req0 & (~req1 | last_grant);
  assign gnt1 = resetn & req1 & (~req0 | ~last_grant);

  always_comb begin
    rom_addr = addr_q;
    unique case (1'b1)
      gnt0:    rom_addr = wa0;
      gnt1:    rom_addr = wa1;
      default: rom_addr = addr_q;
    endcase
  end

  assign resp_data = p_err ? '0 : rom_data;
  assign rvalid0   = p_valid & ~p_port;
  assign rvalid1   = p_valid & p_port;
  assign rerr0     = rvalid0 & p_err;
  assign rerr1     = rvalid1 & p_err;
  assign rdata0    = rvalid0 ? resp_data : rdata0_q;
  assign rdata1    = rvalid1 ? resp_data : rdata1_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      p_valid    <= 1'b0;
      p_port     <= 1'b0;
      p_err      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      busy_cnt   <= '0;
    end else begin
      if (gnt0 | gnt1) begin
        last_grant <= gnt1;
        addr_q     <= rom_addr;
      end
      p_valid <= gnt0 | gnt1;
      p_port  <= gnt1;
      p_err   <= gnt1 ? oor1 : oor0;
      if (rvalid0) rdata0_q <= resp_data;
      if (rvalid1) rdata1_q <= resp_data;
      if (req0 && req1 && busy_cnt != 16'hFFFF)
        busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomized scoreboard bench for inst_rom_arbiter with a
// behavioural ROM and round-robin reference model.
module tb_inst_rom_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req0 = 1'b0;
  logic [31:0] addr0 = '0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        rerr0;
  logic        req1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        rerr1;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [15:0] busy_cnt;

  inst_rom_arbiter #(.ROM_AW(8), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .addr0(addr0), .gnt0(gnt0),
    .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  bit          last_served = 1'b1;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_rd0 = '0;
  logic [31:0] m_rd1 = '0;
  logic [15:0] m_busy = '0;
  bit          m_g0 = 1'b0;
  bit          m_g1 = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) m_busy = '0;
    else if (req0 && req1 && m_busy != 16'hFFFF)
      m_busy = m_busy + 16'd1;
  end

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      #1;
      if (!resetn) begin
        chk(!gnt0 && !gnt1, "rst_gnt", {gnt0, gnt1}, 0);
        chk(!rvalid0 && !rvalid1, "rst_rvalid",
            {rvalid0, rvalid1}, 0);
        chk(!rerr0 && !rerr1, "rst_rerr", {rerr0, rerr1}, 0);
        chk(rdata0 == 0, "rst_rdata0", rdata0, 0);
        chk(rdata1 == 0, "rst_rdata1", rdata1, 0);
        chk(rom_addr == 0, "rst_rom_addr", rom_addr, 0);
        chk(busy_cnt == 0, "rst_busy", busy_cnt, 0);
      end
      q.delete();
      last_served = 1'b1;
      m_addr = '0;
      m_rd0 = '0;
      m_rd1 = '0;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
    end else begin
      bit          eg0;
      bit          eg1;
      bit          p;
      bit          e;
      logic [7:0]  w;
      logic [31:0] a;
      exp_t        it;
      cycle++;
      chk(!(rvalid0 && rvalid1), "rvalid_excl",
          {rvalid0, rvalid1}, 0);
      if (rvalid0 || rvalid1) begin
        p = rvalid1;
        if (q.size() == 0) begin
          chk(0, "stray_rvalid", {rvalid0, rvalid1}, 0);
        end else begin
          it = q.pop_front();
          chk(p == it.port, "resp_port", p, it.port);
          chk(it.due == cycle, "resp_cycle", cycle, it.due);
          if (p) begin
            chk(rdata1 == it.data, "rdata1", rdata1, it.data);
            chk(rerr1 == it.err, "rerr1", rerr1, it.err);
            m_rd1 = it.data;
          end else begin
            chk(rdata0 == it.data, "rdata0", rdata0, it.data);
            chk(rerr0 == it.err, "rerr0", rerr0, it.err);
            m_rd0 = it.data;
          end
        end
      end else if (q.size() != 0 && q[0].due <= cycle) begin
        chk(0, "missing_rvalid", 0, q[0].due);
        void'(q.pop_front());
      end
      if (!rvalid0) begin
        chk(rdata0 == m_rd0, "rdata0_hold", rdata0, m_rd0);
        chk(!rerr0, "rerr0_idle", rerr0, 0);
      end
      if (!rvalid1) begin
        chk(rdata1 == m_rd1, "rdata1_hold", rdata1, m_rd1);
        chk(!rerr1, "rerr1_idle", rerr1, 0);
      end
      // Conflicts go to whichever port was not served last.
      eg0 = req0 && (!req1 || last_served);
      eg1 = req1 && (!req0 || !last_served);
      chk(gnt0 == eg0, "gnt0", gnt0, eg0);
      chk(gnt1 == eg1, "gnt1", gnt1, eg1);
      if (eg0 || eg1) begin
        a = eg1 ? addr1 : addr0;
        w = a[9:2];
        e = (a[31:10] != 0);
        it.port = eg1;
        it.err = e;
        it.data = e ? 32'h0 : rom_mem[w];
        it.due = cycle + 1;
        q.push_back(it);
        last_served = eg1;
        m_addr = w;
      end
      chk(rom_addr == m_addr, "rom_addr", rom_addr, m_addr);
      chk(busy_cnt == m_busy, "busy_cnt", busy_cnt, m_busy);
      m_g0 = eg0;
      m_g1 = eg1;
    end
  end

  task automatic cyc(input logic r0, input logic [31:0] a0,
                     input logic r1, input logic [31:0] a1);
    req0 = r0;
    addr0 = a0;
    req1 = r1;
    addr1 = a1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [21:0] hi;
    logic [9:0]  lo;
    lo = 10'($urandom);
    hi = 22'($urandom_range(1, 22'h3FFFFF));
    if ($urandom_range(0, 7) == 0) return {hi, lo};
    return {22'h0, lo};
  endfunction

  initial begin
    logic        r0;
    logic        r1;
    logic [31:0] a0;
    logic [31:0] a1;
    for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
    rom_mem[4] = 32'h2402_0005;
    #1 resetn = 1'b0;
    #12;
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1, 32'h10, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (4) cyc(1, 32'h0, 1, 32'h4);
    cyc(0, 0, 1, 32'h400);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h8, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(1, 32'h0, 0, 0);
    cyc(1, 32'h4, 0, 0);
    cyc(1, 32'h8, 0, 0);
    cyc(1, 32'hC, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h0, 1, 32'h4);
    cyc(1, 32'h20, 1, 32'h24);
    req0 = 1'b1;
    req1 = 1'b1;
    #2 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1, 32'h30, 1, 32'h34);
    cyc(0, 0, 1, 32'h34);
    cyc(0, 0, 0, 0);
    cyc(1, 32'h14, 1, 32'h14);
    cyc(0, 0, 1, 32'h14);
    r0 = 0;
    r1 = 0;
    a0 = 0;
    a1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!r0 || m_g0) begin
        r0 = ($urandom_range(0, 9) < 6);
        a0 = rand_addr();
      end
      if (!r1 || m_g1) begin
        r1 = ($urandom_range(0, 9) < 6);
        a1 = rand_addr();
      end
      cyc(r0, a0, r1, a1);
    end
    repeat (4) cyc(0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
